// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB master and the peripherals hanging off it.
//   apb_state_e : master FSM states (IDLE, SETUP, ACCESS)
//   APB_ADDR_W  : default PADDR width (32-word register files)
//   APB_DATA_W  : default PWDATA/PRDATA width
//   apb_req_t   : packed {write, addr, wdata} command, shared with the
//                 bus decoder and future slaves
package apb_pkg;

    localparam int APB_ADDR_W = 5;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_watchdog.sv
// apb_watchdog
// Counts ACCESS-phase wait cycles so a slave that never raises PREADY
// cannot hang the bus.
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : zero the count (asserted during SETUP)
//   enable     : count one more wait cycle (ACCESS with PREADY low)
//   expire     : count has reached TIMEOUT-1; the master aborts on this cycle
module apb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign expire = (count == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            // The abort fires at TIMEOUT-1, so holding here never matters
            // functionally; it just guarantees the counter cannot wrap.
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// apb_master
// Single-requester APB master: takes one valid/ready command at a time,
// runs SETUP then ACCESS, honours PREADY wait states, and returns a
// one-cycle response with read data or a watchdog timeout flag.
//   PCLK, PRESETn                : bus clock, synchronous active-low reset
//   req_valid/req_ready          : command handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata : command payload
//   rsp_valid/rsp_rdata/rsp_timeout : one-cycle completion
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB outputs (all registered)
//   PRDATA/PREADY                : APB inputs, only looked at in ACCESS
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    apb_state_e state;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;

    // req_ready is gated by PRESETn combinationally so the requester sees
    // "not ready" for the whole reset cycle, not one cycle late.
    assign req_ready = PRESETn && (state == IDLE);

    assign wd_clear  = (state == SETUP);
    assign wd_enable = (state == ACCESS) && !PREADY;

    apb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            // Response flags are pulses; rsp_rdata holds its last value.
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // The only place the bus payload is loaded, which
                        // keeps it stable across SETUP and every ACCESS cycle.
                        PWRITE <= req_write;
                        PADDR  <= req_addr;
                        PWDATA <= req_wdata;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end else if (wd_expire) begin
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
